// File: rtl/wr_resp_router_1_2_if.sv
// rtl/wr_resp_router_1_2_if.sv - AW tracking and B-channel signal bundle for the 1:2 write-response router
//
// Purpose: groups the AW-tracking, slave B, master B and status signals of the router.
// Modports:
//   slave  - router side: consumes AW_Accept/AW_Master_sel, slave bvalid/bresp and
//            master breadys; drives AW_Allow, M_AXI_bready, both master B outputs
//            and the status outputs.
//   master - environment side (arbiter, slave port, masters): the mirror image.
interface wr_resp_router_1_2_if #(
  parameter int CNT_W = 3
);
  logic             AW_Accept;
  logic             AW_Master_sel;
  logic             AW_Allow;
  logic [1:0]       M_AXI_bresp;
  logic             M_AXI_bvalid;
  logic             M_AXI_bready;
  logic [1:0]       S00_AXI_bresp;
  logic             S00_AXI_bvalid;
  logic             S00_AXI_bready;
  logic [1:0]       S01_AXI_bresp;
  logic             S01_AXI_bvalid;
  logic             S01_AXI_bready;
  logic [CNT_W-1:0] Pending_count;
  logic             Unexpected_b;

  modport slave (
    input  AW_Accept, AW_Master_sel, M_AXI_bresp, M_AXI_bvalid,
           S00_AXI_bready, S01_AXI_bready,
    output AW_Allow, M_AXI_bready, S00_AXI_bresp, S00_AXI_bvalid,
           S01_AXI_bresp, S01_AXI_bvalid, Pending_count, Unexpected_b
  );

  modport master (
    output AW_Accept, AW_Master_sel, M_AXI_bresp, M_AXI_bvalid,
           S00_AXI_bready, S01_AXI_bready,
    input  AW_Allow, M_AXI_bready, S00_AXI_bresp, S00_AXI_bvalid,
           S01_AXI_bresp, S01_AXI_bvalid, Pending_count, Unexpected_b
  );
endinterface

// File: rtl/wr_resp_router_1_2.sv
// rtl/wr_resp_router_1_2.sv - routes the slave B channel back to the owning one of two masters
//
// Purpose: records the owner of every accepted AW in an in-order FIFO and steers each
// B beat to the owner at the FIFO head, popping on the B handshake.
// Ports:
//   ACLK     - clock, all state on rising edge
//   ARESETN  - asynchronous active-low reset
//   bus      - wr_resp_router_1_2_if.slave: AW tracking inputs, AW_Allow, slave B channel,
//              two master B channels, Pending_count, sticky Unexpected_b
module wr_resp_router_1_2 #(
  parameter int OUTSTANDING_DEPTH = 4,
  parameter int CNT_W             = 3
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  wr_resp_router_1_2_if.slave   bus
);
  localparam int               PTR_W     = $clog2(OUTSTANDING_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(OUTSTANDING_DEPTH);

  logic [OUTSTANDING_DEPTH-1:0] r_owner;
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [CNT_W-1:0]             r_count;
  logic                         r_unexp;

  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_m_bready;
  logic w_push;
  logic w_pop;

  // Full/empty come from the count so that wrapped pointers never alias.
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_owner[r_rd_ptr];

  // Only the owning master's bready reaches the slave; nothing is offered while empty.
  assign w_m_bready = ~w_empty & (w_head ? bus.S01_AXI_bready : bus.S00_AXI_bready);

  // A push while full is dropped; the arbiter is expected to honour AW_Allow.
  assign w_push = bus.AW_Accept & ~w_full;
  assign w_pop  = ~w_empty & bus.M_AXI_bvalid & w_m_bready;

  assign bus.AW_Allow       = ~w_full;
  assign bus.M_AXI_bready   = w_m_bready;
  assign bus.S00_AXI_bvalid = ~w_empty & ~w_head & bus.M_AXI_bvalid;
  assign bus.S01_AXI_bvalid = ~w_empty &  w_head & bus.M_AXI_bvalid;
  assign bus.S00_AXI_bresp  = bus.M_AXI_bresp;
  assign bus.S01_AXI_bresp  = bus.M_AXI_bresp;
  assign bus.Pending_count  = r_count;
  assign bus.Unexpected_b   = r_unexp;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_owner  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_unexp  <= 1'b0;
    end else begin
      if (w_push) begin
        r_owner[r_wr_ptr] <= bus.AW_Master_sel;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A response with nothing outstanding is a protocol error; keep it visible until reset.
      if (w_empty && bus.M_AXI_bvalid) begin
        r_unexp <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wr_resp_router_1_2.sv
// tb/tb_wr_resp_router_1_2.sv - self-checking bench for wr_resp_router_1_2
module tb_wr_resp_router_1_2;
  logic ACLK;
  logic ARESETN;
  int   checks;
  int   failures;

  wr_resp_router_1_2_if #(.CNT_W(3)) bus ();

  wr_resp_router_1_2 #(.OUTSTANDING_DEPTH(4), .CNT_W(3)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Model: queue of owners in AW order plus the sticky error flag.
  bit m_q[$];
  bit m_unexp;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_q.delete();
      m_unexp <= 1'b0;
    end else begin
      automatic int  n     = m_q.size();
      automatic bit  rdy   = (n > 0) && (m_q[0] ? bus.S01_AXI_bready : bus.S00_AXI_bready);
      automatic bit  do_pop  = (n > 0) && bus.M_AXI_bvalid && rdy;
      automatic bit  do_push = bus.AW_Accept && (n < 4);
      automatic bit  sel   = bus.AW_Master_sel;
      if (n == 0 && bus.M_AXI_bvalid) m_unexp <= 1'b1;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(sel);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge ACLK) begin
    automatic int  n     = m_q.size();
    automatic bit  own   = (n > 0) ? m_q[0] : 1'b0;
    automatic bit  e_v0  = (n > 0) && !own && bus.M_AXI_bvalid;
    automatic bit  e_v1  = (n > 0) &&  own && bus.M_AXI_bvalid;
    automatic bit  e_rdy = (n > 0) && (own ? bus.S01_AXI_bready : bus.S00_AXI_bready);
    chk("model_count", int'(bus.Pending_count), n);
    chk("model_allow", int'(bus.AW_Allow), int'(n != 4));
    chk("model_m_bready", int'(bus.M_AXI_bready), int'(e_rdy));
    chk("model_s00_bvalid", int'(bus.S00_AXI_bvalid), int'(e_v0));
    chk("model_s01_bvalid", int'(bus.S01_AXI_bvalid), int'(e_v1));
    chk("model_s00_bresp", int'(bus.S00_AXI_bresp), int'(bus.M_AXI_bresp));
    chk("model_s01_bresp", int'(bus.S01_AXI_bresp), int'(bus.M_AXI_bresp));
    chk("model_unexp", int'(bus.Unexpected_b), int'(m_unexp));
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input bit sel);
    bus.AW_Accept     = 1'b1;
    bus.AW_Master_sel = sel;
    step();
    bus.AW_Accept     = 1'b0;
  endtask

  bit exp_own [4];

  initial begin
    checks   = 0;
    failures = 0;
    ARESETN  = 1'b0;
    bus.AW_Accept      = 1'b0;
    bus.AW_Master_sel  = 1'b0;
    bus.M_AXI_bresp    = 2'b00;
    bus.M_AXI_bvalid   = 1'b0;
    bus.S00_AXI_bready = 1'b0;
    bus.S01_AXI_bready = 1'b0;
    #1;
    repeat (3) step();

    // 1. reset state
    chk("rst_count", int'(bus.Pending_count), 0);
    chk("rst_allow", int'(bus.AW_Allow), 1);
    chk("rst_m_bready", int'(bus.M_AXI_bready), 0);
    chk("rst_unexp", int'(bus.Unexpected_b), 0);
    ARESETN = 1'b1;
    step();

    // 2. single write to S00
    push(1'b0);
    chk("t2_count1", int'(bus.Pending_count), 1);
    bus.M_AXI_bresp    = 2'b00;
    bus.M_AXI_bvalid   = 1'b1;
    bus.S00_AXI_bready = 1'b1;
    #1;
    chk("t2_s00_v", int'(bus.S00_AXI_bvalid), 1);
    chk("t2_s01_v", int'(bus.S01_AXI_bvalid), 0);
    chk("t2_m_rdy", int'(bus.M_AXI_bready), 1);
    step();
    bus.M_AXI_bvalid = 1'b0;
    chk("t2_count0", int'(bus.Pending_count), 0);

    // 3. fill, overflow attempt, drain in order
    exp_own = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) push(exp_own[i]);
    chk("t3_full_allow", int'(bus.AW_Allow), 0);
    chk("t3_full_count", int'(bus.Pending_count), 4);
    push(1'b0);
    chk("t3_ovf_count", int'(bus.Pending_count), 4);
    bus.S00_AXI_bready = 1'b1;
    bus.S01_AXI_bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.M_AXI_bresp  = 2'(i);
      bus.M_AXI_bvalid = 1'b1;
      #1;
      chk("t3_s01_v", int'(bus.S01_AXI_bvalid), int'(exp_own[i]));
      chk("t3_s00_v", int'(bus.S00_AXI_bvalid), int'(!exp_own[i]));
      chk("t3_bresp", int'(exp_own[i] ? bus.S01_AXI_bresp : bus.S00_AXI_bresp), i);
      step();
    end
    bus.M_AXI_bvalid = 1'b0;
    chk("t3_drained", int'(bus.Pending_count), 0);

    // 4. owner S01 stalls while S00 is ready
    push(1'b1);
    bus.S01_AXI_bready = 1'b0;
    bus.S00_AXI_bready = 1'b1;
    bus.M_AXI_bresp    = 2'b10;
    bus.M_AXI_bvalid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_m_rdy", int'(bus.M_AXI_bready), 0);
      chk("t4_s01_v", int'(bus.S01_AXI_bvalid), 1);
      chk("t4_s00_v", int'(bus.S00_AXI_bvalid), 0);
      step();
      chk("t4_count", int'(bus.Pending_count), 1);
    end
    bus.S01_AXI_bready = 1'b1;
    step();
    bus.M_AXI_bvalid = 1'b0;
    chk("t4_count0", int'(bus.Pending_count), 0);

    // 5. simultaneous push/pop at count 2, then drain across pointer wrap
    push(1'b0);
    push(1'b1);
    chk("t5_count2", int'(bus.Pending_count), 2);
    bus.AW_Accept      = 1'b1;
    bus.AW_Master_sel  = 1'b0;
    bus.M_AXI_bresp    = 2'b01;
    bus.M_AXI_bvalid   = 1'b1;
    bus.S00_AXI_bready = 1'b1;
    bus.S01_AXI_bready = 1'b1;
    #1;
    chk("t5_both_s00_v", int'(bus.S00_AXI_bvalid), 1);
    step();
    bus.AW_Accept = 1'b0;
    chk("t5_count_same", int'(bus.Pending_count), 2);
    chk("t5_head_s01", int'(bus.S01_AXI_bvalid), 1);
    step();
    chk("t5_wrap_s00", int'(bus.S00_AXI_bvalid), 1);
    chk("t5_wrap_s01", int'(bus.S01_AXI_bvalid), 0);
    step();
    bus.M_AXI_bvalid = 1'b0;
    chk("t5_count0", int'(bus.Pending_count), 0);

    // 6. unexpected response, then reset mid-stream
    bus.M_AXI_bvalid = 1'b1;
    #1;
    chk("t6_unexp_pre", int'(bus.Unexpected_b), 0);
    step();
    bus.M_AXI_bvalid = 1'b0;
    chk("t6_unexp_set", int'(bus.Unexpected_b), 1);
    step();
    chk("t6_unexp_hold", int'(bus.Unexpected_b), 1);
    push(1'b1);
    push(1'b0);
    push(1'b1);
    chk("t6_count3", int'(bus.Pending_count), 3);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("t6_rst_count", int'(bus.Pending_count), 0);
    chk("t6_rst_unexp", int'(bus.Unexpected_b), 0);
    chk("t6_rst_allow", int'(bus.AW_Allow), 1);
    step();
    ARESETN = 1'b1;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
